// File: rtl/fft_reorder_buf_if.sv
// Stream bundle between FFT_PE, the reorder buffer and its consumer.
// The master side drives the FFT pair stream and out_ready; the slave side is the buffer.
interface fft_reorder_buf_if #(
    parameter int DW   = 32,
    parameter int LOGN = 4
);
    logic [DW-1:0]   fft_a;
    logic [DW-1:0]   fft_b;
    logic            fft_pe_valid;
    logic [DW-1:0]   out_data;
    logic [LOGN-1:0] out_idx;
    logic            out_valid;
    logic            out_ready;
    logic            frame_last;
    logic            overflow;

    modport master (
        output fft_a, fft_b, fft_pe_valid, out_ready,
        input  out_data, out_idx, out_valid, frame_last, overflow
    );

    modport slave (
        input  fft_a, fft_b, fft_pe_valid, out_ready,
        output out_data, out_idx, out_valid, frame_last, overflow
    );
endinterface

// File: rtl/fft_reorder_buf.sv
// Ping-pong buffer that takes bit-reversed FFT pairs and streams them out in natural order.
// Bank state | meaning: EMPTY = free, FILLING = partially written, FULL = frame ready to drain.
module fft_reorder_buf #(
    parameter int DW   = 32,
    parameter int N    = 16,
    parameter int LOGN = 4
) (
    input  logic               clk,
    input  logic               rst,
    fft_reorder_buf_if.slave   bus
);
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_st_e;

    bank_st_e          bank_q [2];
    logic              wb_q;
    logic              rb_q;
    logic [LOGN-2:0]   wcnt_q;
    logic [LOGN-1:0]   rcnt_q;
    logic              ovf_q;
    logic [DW-1:0]     mem_q [2][N];

    logic              rd_valid;
    logic              rd_fire;
    logic              rd_wrap;
    logic              rel_wb;
    logic              wr_acc;
    logic              wr_drop;
    logic              wr_wrap;
    logic [LOGN-1:0]   addr_a;
    logic [LOGN-1:0]   addr_b;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = v[LOGN-1-i];
        end
        return r;
    endfunction

    assign addr_a = bitrev({wcnt_q, 1'b0});
    assign addr_b = bitrev({wcnt_q, 1'b1});

    assign rd_valid = (bank_q[rb_q] == FULL);
    assign rd_fire  = rd_valid && bus.out_ready;
    assign rd_wrap  = rd_fire && (rcnt_q == LOGN'(N - 1));

    // A bank drained on this edge can take the first pair of the next frame at once.
    assign rel_wb   = rd_wrap && (rb_q == wb_q);
    assign wr_acc   = bus.fft_pe_valid && ((bank_q[wb_q] != FULL) || rel_wb);
    assign wr_drop  = bus.fft_pe_valid && !wr_acc;
    assign wr_wrap  = wr_acc && (wcnt_q == {(LOGN-1){1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q[0] <= EMPTY;
            bank_q[1] <= EMPTY;
            wb_q      <= 1'b0;
            rb_q      <= 1'b0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (rd_fire) begin
                if (rd_wrap) begin
                    bank_q[rb_q] <= EMPTY;
                    rcnt_q       <= '0;
                    rb_q         <= ~rb_q;
                end else begin
                    rcnt_q <= rcnt_q + 1'b1;
                end
            end
            // Placed after the release so a same-cycle write into the freed bank wins.
            if (wr_acc) begin
                bank_q[wb_q] <= wr_wrap ? FULL : FILLING;
                if (wr_wrap) begin
                    wcnt_q <= '0;
                    wb_q   <= ~wb_q;
                end else begin
                    wcnt_q <= wcnt_q + 1'b1;
                end
            end
            if (wr_drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wb_q][addr_a] <= bus.fft_a;
            mem_q[wb_q][addr_b] <= bus.fft_b;
        end
    end

    assign bus.out_valid  = rd_valid;
    assign bus.out_data   = rd_valid ? mem_q[rb_q][rcnt_q] : '0;
    assign bus.out_idx    = rcnt_q;
    assign bus.frame_last = rd_valid && (rcnt_q == LOGN'(N - 1));
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_fft_reorder_buf.sv
// Directed bench for fft_reorder_buf: a vector table for the basic frame plus
// hand-written sequences for backpressure, ping-pong, overflow, reset and release/write overlap.
module tb_fft_reorder_buf;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_reorder_buf_if #(.DW(DW), .LOGN(4)) bus();

    fft_reorder_buf #(.DW(DW), .N(16), .LOGN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          pv;
        int          j;
        bit          rdy;
        bit          ev;
        logic [3:0]  eidx;
        logic [15:0] ereal;
        bit          elast;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          brv [16];
    logic [31:0] exp_q [$];
    int          exp_k = 0;
    int          n_out = 0;
    bit          hold_chk = 1'b0;
    logic [31:0] hold_data;
    logic [3:0]  hold_idx;
    int          cyc_num = 0;
    int          vcnt = 0;
    int          first_v = -1;
    int          last_v = -1;
    vec_t        tv [25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] smp(input int p, input logic [15:0] tag);
        logic [15:0] im;
        im = (tag == 16'h0) ? 16'h0 : tag + 16'(p);
        return {16'(p), im};
    endfunction

    task automatic cyc(input bit pv, input logic [31:0] a, input logic [31:0] b, input bit rdy);
        logic [31:0] ed;
        bus.fft_pe_valid = pv;
        bus.fft_a        = a;
        bus.fft_b        = b;
        bus.out_ready    = rdy;
        @(negedge clk);
        if (hold_chk) begin
            chk("hold_data", bus.out_data, hold_data);
            chk("hold_idx", 32'(bus.out_idx), 32'(hold_idx));
        end
        hold_chk  = bus.out_valid && !rdy;
        hold_data = bus.out_data;
        hold_idx  = bus.out_idx;
        if (bus.out_valid) begin
            vcnt++;
            if (first_v < 0) first_v = cyc_num;
            last_v = cyc_num;
        end
        if (bus.out_valid && rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'(bus.out_valid), 32'd0);
            end else begin
                ed = exp_q.pop_front();
                chk("out_data", bus.out_data, ed);
                chk("out_idx", 32'(bus.out_idx), 32'(exp_k));
                chk("frame_last", 32'(bus.frame_last), 32'(exp_k == 15));
                exp_k = (exp_k + 1) % 16;
                n_out++;
            end
        end
        cyc_num++;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] tag, input bit rdy);
        for (int j = 0; j < 8; j++) begin
            cyc(1'b1, smp(2*j, tag), smp(2*j+1, tag), rdy);
        end
    endtask

    task automatic push_frame(input logic [15:0] tag);
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(smp(brv[k], tag));
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 32'h0, 32'h0, rdy);
        end
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.fft_pe_valid = 1'b0;
        bus.fft_a        = '0;
        bus.fft_b        = '0;
        bus.out_ready    = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        hold_chk = 1'b0;
        exp_q.delete();
        exp_k    = 0;
    endtask

    task automatic clr_stats();
        n_out   = 0;
        vcnt    = 0;
        first_v = -1;
        last_v  = -1;
        cyc_num = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_data"}, bus.out_data, 32'd0);
        chk({tag, "_idx"}, 32'(bus.out_idx), 32'd0);
        chk({tag, "_last"}, 32'(bus.frame_last), 32'd0);
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
    endtask

    initial begin
        brv = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        for (int c = 0; c < 8; c++) tv[c] = '{1'b1, c, 1'b1, 1'b0, 4'd0, 16'd0, 1'b0};
        for (int k = 0; k < 16; k++) tv[8+k] = '{1'b0, 0, 1'b1, 1'b1, 4'(k), 16'(brv[k]), (k == 15)};
        tv[24] = '{1'b0, 0, 1'b1, 1'b0, 4'd0, 16'd0, 1'b0};

        rst              = 1'b1;
        bus.fft_pe_valid = 1'b0;
        bus.fft_a        = '0;
        bus.fft_b        = '0;
        bus.out_ready    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic frame from the vector table
        for (int c = 0; c < 25; c++) begin
            bus.fft_pe_valid = tv[c].pv;
            bus.fft_a        = smp(2*tv[c].j, 16'h0);
            bus.fft_b        = smp(2*tv[c].j+1, 16'h0);
            bus.out_ready    = tv[c].rdy;
            @(negedge clk);
            chk("t1_valid", 32'(bus.out_valid), 32'(tv[c].ev));
            chk("t1_idx", 32'(bus.out_idx), 32'(tv[c].eidx));
            chk("t1_last", 32'(bus.frame_last), 32'(tv[c].elast));
            if (tv[c].ev) begin
                chk("t1_data", bus.out_data, {tv[c].ereal, 16'h0000});
            end
            @(posedge clk);
            #1;
        end
        chk("t1_ovf", 32'(bus.overflow), 32'd0);

        // Toggling out_ready
        clr_stats();
        send_frame(16'h0, 1'b0);
        push_frame(16'h0);
        for (int i = 0; i < 32; i++) begin
            cyc(1'b0, 32'h0, 32'h0, (i % 2) == 0);
        end
        chk("t2_delivered", 32'(n_out), 32'd16);
        chk("t2_left", 32'(exp_q.size()), 32'd0);
        chk("t2_valid_end", 32'(bus.out_valid), 32'd0);

        // Ping-pong: second frame fills while the first drains
        clr_stats();
        send_frame(16'h0, 1'b1);
        push_frame(16'h0);
        idle(8, 1'b1);
        send_frame(16'hA000, 1'b1);
        push_frame(16'hA000);
        idle(16, 1'b1);
        chk("t3_delivered", 32'(n_out), 32'd32);
        chk("t3_valid_cycles", 32'(vcnt), 32'd32);
        chk("t3_span", 32'(last_v - first_v + 1), 32'd32);
        chk("t3_ovf", 32'(bus.overflow), 32'd0);

        // Overflow on the third frame with the consumer stalled
        clr_stats();
        send_frame(16'h1000, 1'b0);
        push_frame(16'h1000);
        send_frame(16'h5000, 1'b0);
        push_frame(16'h5000);
        chk("t4_ovf_before", 32'(bus.overflow), 32'd0);
        cyc(1'b1, smp(0, 16'h7000), smp(1, 16'h7000), 1'b0);
        chk("t4_ovf_set", 32'(bus.overflow), 32'd1);
        for (int j = 1; j < 8; j++) begin
            cyc(1'b1, smp(2*j, 16'h7000), smp(2*j+1, 16'h7000), 1'b0);
        end
        idle(36, 1'b1);
        chk("t4_delivered", 32'(n_out), 32'd32);
        chk("t4_left", 32'(exp_q.size()), 32'd0);
        chk("t4_ovf_sticky", 32'(bus.overflow), 32'd1);

        // Reset mid-frame with a full frame waiting
        clr_stats();
        send_frame(16'h2000, 1'b0);
        for (int j = 0; j < 5; j++) begin
            cyc(1'b1, smp(2*j, 16'h2400), smp(2*j+1, 16'h2400), 1'b0);
        end
        chk("t5_valid_before", 32'(bus.out_valid), 32'd1);
        do_reset();
        @(negedge clk);
        chk_all_zero("t5_after_rst");
        @(posedge clk);
        #1;
        send_frame(16'h3000, 1'b1);
        push_frame(16'h3000);
        idle(20, 1'b1);
        chk("t5_delivered", 32'(n_out), 32'd16);
        chk("t5_left", 32'(exp_q.size()), 32'd0);

        // Release of a full bank coinciding with a new pair into that bank
        clr_stats();
        send_frame(16'h4000, 1'b0);
        push_frame(16'h4000);
        send_frame(16'h6000, 1'b0);
        push_frame(16'h6000);
        idle(3, 1'b0);
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 32'h0, 32'h0, 1'b1);
        end
        chk("t6_at_last", 32'(bus.frame_last), 32'd1);
        for (int j = 0; j < 8; j++) begin
            cyc(1'b1, smp(2*j, 16'h8000), smp(2*j+1, 16'h8000), 1'b1);
        end
        push_frame(16'h8000);
        chk("t6_ovf", 32'(bus.overflow), 32'd0);
        idle(40, 1'b1);
        chk("t6_delivered", 32'(n_out), 32'd48);
        chk("t6_left", 32'(exp_q.size()), 32'd0);
        chk("t6_ovf_end", 32'(bus.overflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
